// File: rtl/alu_pkg.sv
// Shared types and flag helper for the alu16 issue/writeback stage.
package alu_pkg;

  localparam int DW = 16;

  typedef enum logic [2:0] {
    OP_OR    = 3'b000,
    OP_AND   = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_PASSB = 3'b100,
    OP_INC   = 3'b101,
    OP_ADD   = 3'b110,
    OP_SUB   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } alu_flags_t;

  // Overflow is only meaningful for the arithmetic ops; loads never overflow.
  function automatic alu_flags_t calc_flags(input logic ld, input alu_op_e op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [DW-1:0] res);
    alu_flags_t f;
    f.n = res[DW-1];
    f.z = (res == {DW{1'b0}});
    f.v = 1'b0;
    if (!ld) begin
      case (op)
        OP_ADD:  f.v = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
        OP_SUB:  f.v = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
        OP_INC:  f.v = (a == 16'h7FFF);
        default: f.v = 1'b0;
      endcase
    end else begin
      f.v = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x DW, two operand read ports, a debug read port, one write port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int RA    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RA-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RA-1:0] raddr1,
  input  logic [RA-1:0] raddr2,
  input  logic [RA-1:0] dbg_addr,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] rf_r [NREGS];

  // Register storage, cleared asynchronously and written once per instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= 16'h0000;
      end
    end else if (we) begin
      rf_r[waddr] <= wdata;
    end
  end

  assign rdata1   = rf_r[raddr1];
  assign rdata2   = rf_r[raddr2];
  assign dbg_data = rf_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand issue and writeback control for alu16: IDLE -> EXEC -> RESP handshake sequencer.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int RA    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          instr_ld,
  input  logic [2:0]    instr_op,
  input  logic [RA-1:0] instr_rd,
  input  logic [RA-1:0] instr_rs1,
  input  logic [RA-1:0] instr_rs2,
  input  logic [DW-1:0] instr_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_z,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [2:0]    res_flags,
  input  logic [RA-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  issue_state_e  state_r, state_next_s;
  logic          ld_r;
  alu_op_e       op_r;
  logic [RA-1:0] rd_r, rs1_r, rs2_r;
  logic [DW-1:0] imm_r;
  logic [DW-1:0] rdata1_s, rdata2_s, wb_data_s;
  logic          we_s, accept_s;
  logic [DW-1:0] res_data_r;
  alu_flags_t    res_flags_r, flags_s;

  alu_regfile #(.NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (we_s),
    .waddr    (rd_r),
    .wdata    (wb_data_s),
    .raddr1   (rs1_r),
    .raddr2   (rs2_r),
    .dbg_addr (dbg_addr),
    .rdata1   (rdata1_s),
    .rdata2   (rdata2_s),
    .dbg_data (dbg_data)
  );

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign instr_ready = (state_r == IDLE) && !rst;
  assign accept_s    = instr_valid && instr_ready;
  assign res_valid   = (state_r == RESP);
  assign res_data    = res_data_r;
  assign res_flags   = res_flags_r;
  assign wb_data_s   = ld_r ? imm_r : alu_z;
  assign flags_s     = calc_flags(ld_r, op_r, alu_a, alu_b, wb_data_s);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; ALU operands are only driven during the single EXEC cycle.
  always_comb begin
    state_next_s = state_r;
    we_s         = 1'b0;
    alu_a        = 16'h0000;
    alu_b        = 16'h0000;
    alu_op       = 3'b000;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        alu_a        = rdata1_s;
        alu_b        = rdata2_s;
        alu_op       = op_r;
        we_s         = 1'b1;
        state_next_s = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Instruction fields captured on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_r  <= 1'b0;
      op_r  <= OP_OR;
      rd_r  <= '0;
      rs1_r <= '0;
      rs2_r <= '0;
      imm_r <= 16'h0000;
    end else if (accept_s) begin
      ld_r  <= instr_ld;
      op_r  <= alu_op_e'(instr_op);
      rd_r  <= instr_rd;
      rs1_r <= instr_rs1;
      rs2_r <= instr_rs2;
      imm_r <= instr_imm;
    end
  end

  // Result and flags, frozen from the end of EXEC until the next instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_r  <= 16'h0000;
      res_flags_r <= '0;
    end else if (we_s) begin
      res_data_r  <= wb_data_s;
      res_flags_r <= flags_s;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed-vector bench for alu_issue_ctrl with a behavioural alu16 attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready, instr_ld;
  logic [2:0]  instr_op, instr_rd, instr_rs1, instr_rs2;
  logic [15:0] instr_imm;
  logic [15:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_flags;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_ld(instr_ld),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural alu16.
  always_comb begin
    case (alu_op)
      3'b000:  alu_z = alu_a | alu_b;
      3'b001:  alu_z = alu_a & alu_b;
      3'b010:  alu_z = alu_a ^ alu_b;
      3'b011:  alu_z = ~(alu_a & alu_b);
      3'b100:  alu_z = alu_b;
      3'b101:  alu_z = alu_a + 16'd1;
      3'b110:  alu_z = alu_a + alu_b;
      default: alu_z = alu_a - alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one instruction from IDLE and stop at the EXEC-cycle negedge.
  task automatic send(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm);
    @(negedge clk);
    check("ready_idle", {15'd0, instr_ready}, 16'd1);
    check("alu_op_idle", {13'd0, alu_op}, 16'd0);
    instr_ld = ld; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("ready_exec", {15'd0, instr_ready}, 16'd0);
    if (!ld) check("alu_op_exec", {13'd0, alu_op}, {13'd0, op});
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_wait", {15'd0, res_valid}, 16'd1);
  endtask

  task automatic take_res(input string tag, input logic [2:0] rd,
                          input logic [15:0] exp_data, input logic [2:0] exp_flags);
    wait_res();
    check({tag, "_data"}, res_data, exp_data);
    check({tag, "_flags"}, {13'd0, res_flags}, {13'd0, exp_flags});
    check({tag, "_alu_op_resp"}, {13'd0, alu_op}, 16'd0);
    dbg_addr = rd;
    #1 check({tag, "_rf"}, dbg_data, exp_data);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic ld, input logic [2:0] op,
                     input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic [15:0] imm, input logic [15:0] exp_data,
                     input logic [2:0] exp_flags);
    send(ld, op, rd, rs1, rs2, imm);
    take_res(tag, rd, exp_data, exp_flags);
  endtask

  initial begin
    logic [15:0] held;
    rst = 1'b1; instr_valid = 1'b0; instr_ld = 1'b0; instr_op = 3'd0;
    instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_imm = 16'h0;
    res_ready = 1'b0; dbg_addr = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {15'd0, instr_ready}, 16'd0);
    check("rst_res_valid", {15'd0, res_valid}, 16'd0);
    check("rst_res_data", res_data, 16'h0000);
    rst = 1'b0;

    // 1: reset while a result waits in RESP
    send(1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 16'h1234);
    wait_res();
    check("t1_pre_data", res_data, 16'h1234);
    rst = 1'b1;
    #1 check("t1_valid_drop", {15'd0, res_valid}, 16'd0);
    check("t1_data_clr", res_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t1_ready_after", {15'd0, instr_ready}, 16'd1);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 check("t1_rf_clear", dbg_data, 16'h0000);
    end

    // 2: overflow into the sign bit
    run("t2_ld_r1", 1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 3'b000);
    run("t2_ld_r2", 1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 3'b000);
    run("t2_add", 1'b0, 3'b110, 3'd3, 3'd1, 3'd2, 16'h0, 16'h8000, 3'b101);

    // 3: zero result and increment overflow
    run("t3_sub", 1'b0, 3'b111, 3'd4, 3'd2, 3'd2, 16'h0, 16'h0000, 3'b010);
    run("t3_inc", 1'b0, 3'b101, 3'd5, 3'd1, 3'd0, 16'h0, 16'h8000, 3'b101);

    // 4: consumer stalls; a second instruction is offered but must not be taken
    send(1'b1, 3'd0, 3'd7, 3'd0, 3'd0, 16'h5A5A);
    wait_res();
    held = res_data;
    check("t4_held_init", held, 16'h5A5A);
    instr_ld = 1'b1; instr_rd = 3'd0; instr_imm = 16'hAAAA; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_valid_hold", {15'd0, res_valid}, 16'd1);
      check("t4_data_hold", res_data, held);
      check("t4_ready_low", {15'd0, instr_ready}, 16'd0);
    end
    instr_valid = 1'b0;
    take_res("t4_release", 3'd7, 16'h5A5A, 3'b000);
    dbg_addr = 3'd0;
    #1 check("t4_r0_untouched", dbg_data, 16'h0000);

    // 5: dependent back-to-back adds with rd == rs1 == rs2
    run("t5_ld_r1", 1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 16'h0003, 16'h0003, 3'b000);
    run("t5_add1", 1'b0, 3'b110, 3'd1, 3'd1, 3'd1, 16'h0, 16'h0006, 3'b000);
    run("t5_add2", 1'b0, 3'b110, 3'd1, 3'd1, 3'd1, 16'h0, 16'h000C, 3'b000);

    // 6: logical ops
    run("t6_ld_r6", 1'b1, 3'd0, 3'd6, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 3'b100);
    run("t6_nand", 1'b0, 3'b011, 3'd7, 3'd6, 3'd6, 16'h0, 16'h0000, 3'b010);
    run("t6_passb", 1'b0, 3'b100, 3'd0, 3'd1, 3'd6, 16'h0, 16'hFFFF, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
